// File: rtl/key_scheduler.sv
// Button-to-command scheduler: debounces 15 buttons, auto-repeats codes 0x7-0xC,
// and issues one code per slot through an IDLE/ISSUE/GAP arbiter.
module key_lane #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);
  logic       s1, s2, flip;
  logic [7:0] cnt;

  assign flip = (s2 != level) && (cnt == 8'(DEBOUNCE_CYCLES - 1));
  assign rise = flip & ~level;
  assign fall = flip & level;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == level) cnt <= '0;
      else if (flip) begin
        cnt   <= '0;
        level <= ~level;
      end else cnt <= cnt + 8'd1;
    end
  end
endmodule

module key_scheduler #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_RATE     = 16,
  parameter int GAP_CYCLES      = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [14:0] btn,
  output logic [3:0]  inCode,
  output logic        codeValid,
  output logic        lostEvent
);
  localparam int          NUM_LANES  = 15;
  localparam logic [14:0] REPEATABLE = 15'h1F80;

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  logic [NUM_LANES-1:0] level, rise, fall, pending, set_vec, clr_vec, rep_press;
  logic [3:0]  rep_idx, rep_new, low_idx, idx, idx_n;
  logic [15:0] rep_cnt;
  logic        rep_arm, rep_fire;
  logic [3:0]  gap_cnt, gap_n;
  state_t      state, state_n;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    key_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
      .clock(clock), .reset(reset), .raw(btn[i]),
      .level(level[i]), .rise(rise[i]), .fall(fall[i])
    );
  end

  assign rep_press = rise & REPEATABLE;

  always_comb begin
    rep_new = 4'd0;
    low_idx = 4'd0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (rep_press[i]) rep_new = 4'(i);
      if (pending[i])   low_idx = 4'(i);
    end
  end

  // A repeat only fires while the tracked button remains high after this edge.
  assign rep_fire = rep_arm && !(|rep_press) && (rep_cnt == 16'd1) &&
                    level[rep_idx] && !fall[rep_idx];

  always_ff @(posedge clock) begin
    if (reset) begin
      rep_arm <= 1'b0;
      rep_idx <= 4'd0;
      rep_cnt <= '0;
    end else if (|rep_press) begin
      rep_arm <= 1'b1;
      rep_idx <= rep_new;
      rep_cnt <= 16'(REPEAT_DELAY);
    end else if (rep_arm) begin
      if (!level[rep_idx] || fall[rep_idx]) rep_arm <= 1'b0;
      else if (rep_cnt == 16'd1)           rep_cnt <= 16'(REPEAT_RATE);
      else                                  rep_cnt <= rep_cnt - 16'd1;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    gap_n   = gap_cnt;
    clr_vec = '0;
    case (state)
      IDLE: if (|pending) begin
        state_n = ISSUE;
        idx_n   = low_idx;
      end
      ISSUE: begin
        clr_vec[idx] = 1'b1;
        state_n      = GAP;
        gap_n        = 4'd0;
      end
      GAP: begin
        // Exit re-runs the IDLE decision so back-to-back codes sit GAP_CYCLES+1 apart.
        if (gap_cnt == 4'(GAP_CYCLES - 1)) begin
          if (|pending) begin
            state_n = ISSUE;
            idx_n   = low_idx;
          end else state_n = IDLE;
        end else gap_n = gap_cnt + 4'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  assign set_vec = rise | (rep_fire ? (15'd1 << rep_idx) : 15'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= 4'd0;
      gap_cnt   <= 4'd0;
      pending   <= '0;
      inCode    <= 4'hF;
      codeValid <= 1'b0;
      lostEvent <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      gap_cnt   <= gap_n;
      pending   <= (pending & ~clr_vec) | set_vec;
      inCode    <= (state_n == ISSUE) ? idx_n : 4'hF;
      codeValid <= (state_n == ISSUE);
      if (|(set_vec & pending & ~clr_vec)) lostEvent <= 1'b1;
    end
  end
endmodule

// File: tb/tb_key_scheduler.sv
// Directed bench for key_scheduler with short debounce/repeat timing.
module tb_key_scheduler;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [14:0] btn = '0;
  logic [3:0]  inCode;
  logic        codeValid, lostEvent;

  key_scheduler #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_RATE(8), .GAP_CYCLES(2)) dut (
    .clock(clock), .reset(reset), .btn(btn),
    .inCode(inCode), .codeValid(codeValid), .lostEvent(lostEvent)
  );

  always #5 clock = ~clock;

  typedef struct {
    string           name;
    logic [14:0]     mask;
    int              hold;
    int              run;
    int              n;
    logic [7:0][7:0] edg;
    logic [7:0][3:0] code;
    logic            lost;
  } vec_t;

  vec_t vecs[8];
  int   nv = 0;
  int   checks = 0, errors = 0;
  int   got_n, bad_valid;
  int   got_e[32];
  logic [3:0] got_c[32];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic [14:0] m, input int h, input int r, input logic l);
    vecs[nv].name = nm; vecs[nv].mask = m; vecs[nv].hold = h; vecs[nv].run = r;
    vecs[nv].n = 0; vecs[nv].edg = '0; vecs[nv].code = '0; vecs[nv].lost = l;
    nv++;
  endtask

  task automatic add_ev(input int e, input logic [3:0] c);
    vecs[nv-1].edg[vecs[nv-1].n]  = 8'(e);
    vecs[nv-1].code[vecs[nv-1].n] = c;
    vecs[nv-1].n++;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    btn   = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // Edge k is the k-th posedge after btn is applied; outputs sampled 1ns later.
  task automatic capture(input int hold, input int run);
    got_n = 0; bad_valid = 0;
    for (int k = 1; k <= run; k++) begin
      @(posedge clock); #1;
      if (codeValid !== (inCode != 4'hF)) bad_valid++;
      if (codeValid === 1'b1 && got_n < 32) begin
        got_e[got_n] = k;
        got_c[got_n] = inCode;
        got_n++;
      end
      if (k == hold) btn = '0;
    end
  endtask

  initial begin
    add("single3", 15'h0008, 30, 40, 1'b0); add_ev(7, 4'h3);
    add("glitch5", 15'h0020, 3, 30, 1'b0);
    add("edge5",   15'h0020, 4, 30, 1'b0); add_ev(7, 4'h5);
    add("simul",   15'h4001, 30, 40, 1'b0); add_ev(7, 4'h0); add_ev(10, 4'hE);
    add("rptB",    15'h0800, 58, 90, 1'b0);
    add_ev(7, 4'hB); add_ev(27, 4'hB); add_ev(35, 4'hB); add_ev(43, 4'hB); add_ev(51, 4'hB); add_ev(59, 4'hB);
    add("oneD",    15'h2000, 60, 80, 1'b0); add_ev(7, 4'hD);
    add("ovf",     15'h00FF, 24, 45, 1'b1);
    for (int i = 0; i < 8; i++) add_ev(7 + 3 * i, 4'(i));

    do_reset();
    chk("rst_code", int'(inCode), 15);
    chk("rst_valid", int'(codeValid), 0);
    chk("rst_lost", int'(lostEvent), 0);

    for (int v = 0; v < nv; v++) begin
      do_reset();
      btn = vecs[v].mask;
      capture(vecs[v].hold, vecs[v].run);
      chk({vecs[v].name, "_count"}, got_n, vecs[v].n);
      for (int j = 0; j < vecs[v].n && j < got_n; j++) begin
        chk($sformatf("%s_edge%0d", vecs[v].name, j), got_e[j], int'(vecs[v].edg[j]));
        chk($sformatf("%s_code%0d", vecs[v].name, j), int'(got_c[j]), int'(vecs[v].code[j]));
      end
      chk({vecs[v].name, "_lost"}, int'(lostEvent), int'(vecs[v].lost));
      chk({vecs[v].name, "_valid"}, bad_valid, 0);
    end

    // lostEvent from the overflow run must clear on reset
    do_reset();
    chk("lost_cleared", int'(lostEvent), 0);

    // Reset during the ISSUE cycle of 0x2 with the button still held
    btn = 15'h0004;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clock); #1;
    end
    chk("mid_issue_code", int'(inCode), 2);
    chk("mid_issue_valid", int'(codeValid), 1);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("abort_code", int'(inCode), 15);
    chk("abort_valid", int'(codeValid), 0);
    reset = 1'b0;
    capture(100, 15);
    chk("reissue_count", got_n, 1);
    if (got_n > 0) begin
      chk("reissue_edge", got_e[0], 7);
      chk("reissue_code", int'(got_c[0]), 2);
    end
    chk("reissue_lost", int'(lostEvent), 0);
    chk("reissue_valid", bad_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
